// File: rtl/gb_cpu_common_pkg.sv
// Shared CPU types: 8-bit ALU opcodes and instruction word, 16-bit sequencer ops,
// flag bit positions, and the per-byte step helpers used by the 16-bit sequencer.
package gb_cpu_common_pkg;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        ADC = 3'd1,
        SUB = 3'd2,
        SBC = 3'd3,
        CP  = 3'd4
    } alu_opcode_t;

    typedef struct packed {
        alu_opcode_t opcode;
        logic [7:0]  a;
        logic [7:0]  b;
    } alu_instruction_t;

    typedef enum logic [1:0] {
        ADD16     = 2'd0,
        ADD_SP_E8 = 2'd1,
        INC16     = 2'd2,
        DEC16     = 2'd3
    } alu16_op_t;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_H = 1;
    localparam int FLAG_C = 0;

    localparam alu_instruction_t ALU_NOP = '{opcode: ADD, a: 8'h00, b: 8'h00};

    function automatic alu_instruction_t lo_step(input alu16_op_t op,
                                                 input logic [7:0] a_lo,
                                                 input logic [7:0] b_lo);
        alu_instruction_t ins;
        ins.a = a_lo;
        case (op)
            ADD16, ADD_SP_E8: begin ins.opcode = ADD; ins.b = b_lo;  end
            INC16:            begin ins.opcode = ADD; ins.b = 8'h01; end
            default:          begin ins.opcode = SUB; ins.b = 8'h01; end
        endcase
        return ins;
    endfunction

    // e8 is sign-extended, so its high byte is all copies of bit 7.
    function automatic alu_instruction_t hi_step(input alu16_op_t op,
                                                 input logic [7:0] a_hi,
                                                 input logic [7:0] b_hi,
                                                 input logic       e8_sign);
        alu_instruction_t ins;
        ins.a = a_hi;
        case (op)
            ADD16:     begin ins.opcode = ADC; ins.b = b_hi;          end
            ADD_SP_E8: begin ins.opcode = ADC; ins.b = {8{e8_sign}};  end
            INC16:     begin ins.opcode = ADC; ins.b = 8'h00;         end
            default:   begin ins.opcode = SBC; ins.b = 8'h00;         end
        endcase
        return ins;
    endfunction

endpackage

// File: rtl/gb_cpu_alu16_seq.sv
// Runs 16-bit ADD/INC/DEC as two chained byte operations on the external 8-bit ALU,
// low byte first, and assembles the 16-bit result plus the architectural flags.
module gb_cpu_alu16_seq
    import gb_cpu_common_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  alu16_op_t        op,
    input  logic [15:0]      operand_a,
    input  logic [15:0]      operand_b,
    input  logic [3:0]       flags_in,
    output logic             busy,
    output logic             done,
    output logic [15:0]      result,
    output logic [3:0]       flags_out,
    output alu_instruction_t instruction,
    output logic             carry_in,
    input  logic [7:0]       out,
    input  logic             Z,
    input  logic             N,
    input  logic             H,
    input  logic             C
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    alu_instruction_t instruction_next;
    logic             carry_next;
    logic             accept;

    // Only the bytes the HIGH step still needs are kept; LOW is issued from the live inputs.
    alu16_op_t   op_reg;
    logic [7:0]  a_hi_reg;
    logic [7:0]  b_hi_reg;
    logic        e8_sign_reg;
    logic [3:0]  flags_lat_reg;
    logic [7:0]  lo_out_reg;
    logic        lo_h_reg;
    logic        lo_c_reg;
    logic [3:0]  flags_next;

    logic        alu_zn_unused;
    assign alu_zn_unused = Z ^ N;

    assign busy = (state_reg == LOW) || (state_reg == HIGH);
    assign done = (state_reg == DONE);

    always_comb begin
        state_next       = state_reg;
        instruction_next = ALU_NOP;
        carry_next       = 1'b0;
        accept           = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                state_next = IDLE;
                if (start) begin
                    accept           = 1'b1;
                    state_next       = LOW;
                    instruction_next = lo_step(op, operand_a[7:0], operand_b[7:0]);
                end
            end
            LOW: begin
                state_next       = HIGH;
                instruction_next = hi_step(op_reg, a_hi_reg, b_hi_reg, e8_sign_reg);
                carry_next       = C;
            end
            HIGH:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // H/C from the high byte are the bit-11/bit-15 carries for ADD HL,rr; ADD SP,e8 uses the low byte's.
    always_comb begin
        flags_next = flags_lat_reg;
        case (op_reg)
            ADD16: begin
                flags_next[FLAG_Z] = flags_lat_reg[FLAG_Z];
                flags_next[FLAG_N] = 1'b0;
                flags_next[FLAG_H] = H;
                flags_next[FLAG_C] = C;
            end
            ADD_SP_E8: begin
                flags_next[FLAG_Z] = 1'b0;
                flags_next[FLAG_N] = 1'b0;
                flags_next[FLAG_H] = lo_h_reg;
                flags_next[FLAG_C] = lo_c_reg;
            end
            default: flags_next = flags_lat_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            instruction   <= ALU_NOP;
            carry_in      <= 1'b0;
            result        <= 16'h0000;
            flags_out     <= 4'h0;
            op_reg        <= ADD16;
            a_hi_reg      <= 8'h00;
            b_hi_reg      <= 8'h00;
            e8_sign_reg   <= 1'b0;
            flags_lat_reg <= 4'h0;
            lo_out_reg    <= 8'h00;
            lo_h_reg      <= 1'b0;
            lo_c_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            instruction <= instruction_next;
            carry_in    <= carry_next;
            if (accept) begin
                op_reg        <= op;
                a_hi_reg      <= operand_a[15:8];
                b_hi_reg      <= operand_b[15:8];
                e8_sign_reg   <= operand_b[7];
                flags_lat_reg <= flags_in;
            end
            if (state_reg == LOW) begin
                lo_out_reg <= out;
                lo_h_reg   <= H;
                lo_c_reg   <= C;
            end
            if (state_reg == HIGH) begin
                result    <= {out, lo_out_reg};
                flags_out <= flags_next;
            end
        end
    end

endmodule

// File: tb/tb_gb_cpu_alu16_seq.sv
// Bench for gb_cpu_alu16_seq: behavioural 8-bit ALU alongside the DUT, directed table,
// random ops against a 16-bit arithmetic model, and start/reset corner sequences.
module tb_gb_cpu_alu16_seq;
    import gb_cpu_common_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    alu16_op_t        op;
    logic [15:0]      operand_a, operand_b;
    logic [3:0]       flags_in;
    logic             busy, done;
    logic [15:0]      result;
    logic [3:0]       flags_out;
    alu_instruction_t instruction;
    logic             carry_in;
    logic [7:0]       alu_out;
    logic             alu_z, alu_n, alu_h, alu_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gb_cpu_alu16_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .flags_in(flags_in),
        .busy(busy), .done(done), .result(result), .flags_out(flags_out),
        .instruction(instruction), .carry_in(carry_in),
        .out(alu_out), .Z(alu_z), .N(alu_n), .H(alu_h), .C(alu_c)
    );

    // Combinational Game Boy 8-bit ALU (add/sub family only).
    always_comb begin
        logic [8:0] full;
        logic [4:0] half;
        logic [7:0] cin;
        full  = 9'h000;
        half  = 5'h00;
        cin   = 8'h00;
        alu_n = 1'b0;
        case (instruction.opcode)
            ADC, SBC: cin = {7'h00, carry_in};
            default:  cin = 8'h00;
        endcase
        case (instruction.opcode)
            SUB, SBC, CP: begin
                full  = {1'b0, instruction.a} - {1'b0, instruction.b} - {1'b0, cin};
                half  = {1'b0, instruction.a[3:0]} - {1'b0, instruction.b[3:0]} - {1'b0, cin[3:0]};
                alu_n = 1'b1;
            end
            default: begin
                full = {1'b0, instruction.a} + {1'b0, instruction.b} + {1'b0, cin};
                half = {1'b0, instruction.a[3:0]} + {1'b0, instruction.b[3:0]} + {1'b0, cin[3:0]};
            end
        endcase
        alu_out = full[7:0];
        alu_h   = half[4];
        alu_c   = full[8];
        alu_z   = (full[7:0] == 8'h00);
    end

    function automatic void ref_model(input alu16_op_t o, input logic [15:0] a, input logic [15:0] b,
                                      input logic [3:0] f, output logic [15:0] r, output logic [3:0] fl);
        int ia = int'(a);
        int ib = int'(b);
        int e8 = b[7] ? int'(b[7:0]) - 256 : int'(b[7:0]);
        case (o)
            ADD16: begin
                r  = 16'(ia + ib);
                fl = {f[3], 1'b0, ((ia & 'hfff) + (ib & 'hfff)) > 'hfff, (ia + ib) > 'hffff};
            end
            ADD_SP_E8: begin
                r  = 16'(ia + e8);
                fl = {2'b00, ((ia & 15) + (ib & 15)) > 15, ((ia & 255) + (ib & 255)) > 255};
            end
            INC16:   begin r = 16'(ia + 1); fl = f; end
            default: begin r = 16'(ia - 1); fl = f; end
        endcase
    endfunction

    function automatic logic [18:0] exp_lo(input alu16_op_t o, input logic [15:0] a, input logic [15:0] b);
        case (o)
            ADD16, ADD_SP_E8: return {ADD, a[7:0], b[7:0]};
            INC16:            return {ADD, a[7:0], 8'h01};
            default:          return {SUB, a[7:0], 8'h01};
        endcase
    endfunction

    function automatic logic [18:0] exp_hi(input alu16_op_t o, input logic [15:0] a, input logic [15:0] b);
        case (o)
            ADD16:     return {ADC, a[15:8], b[15:8]};
            ADD_SP_E8: return {ADC, a[15:8], (b[7] ? 8'hFF : 8'h00)};
            INC16:     return {ADC, a[15:8], 8'h00};
            default:   return {SBC, a[15:8], 8'h00};
        endcase
    endfunction

    function automatic logic exp_carry(input alu16_op_t o, input logic [15:0] a, input logic [15:0] b);
        case (o)
            ADD16, ADD_SP_E8: return (int'(a[7:0]) + int'(b[7:0])) > 255;
            INC16:            return a[7:0] == 8'hFF;
            default:          return a[7:0] == 8'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Drives start now (caller is at a negedge) and follows the op to its done cycle.
    task automatic do_op(input alu16_op_t o, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] f, input logic [15:0] er, input logic [3:0] ef,
                         input string tag);
        int cyc;
        start = 1'b1; op = o; operand_a = a; operand_b = b; flags_in = f;
        @(negedge clk);
        start = 1'b0;
        operand_a = 16'($urandom); operand_b = 16'($urandom); flags_in = 4'($urandom);
        check({tag, " busy@low"}, 32'(busy), 32'd1);
        check({tag, " done@low"}, 32'(done), 32'd0);
        check({tag, " instr@low"}, 32'(instruction), 32'(exp_lo(o, a, b)));
        check({tag, " cin@low"}, 32'(carry_in), 32'd0);
        @(negedge clk);
        check({tag, " busy@high"}, 32'(busy), 32'd1);
        check({tag, " done@high"}, 32'(done), 32'd0);
        check({tag, " instr@high"}, 32'(instruction), 32'(exp_hi(o, a, b)));
        check({tag, " cin@high"}, 32'(carry_in), 32'(exp_carry(o, a, b)));
        cyc = 2;
        while (!done && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'd3);
        check({tag, " busy@done"}, 32'(busy), 32'd0);
        check({tag, " instr@done"}, 32'(instruction), 32'(ALU_NOP));
        check({tag, " result"}, 32'(result), 32'(er));
        check({tag, " flags"}, 32'(flags_out), 32'(ef));
        $display("op %-12s a=%04h b=%04h f=%04b -> result=%04h flags=%04b (exp %04h %04b)",
                 tag, a, b, f, result, flags_out, er, ef);
    endtask

    typedef struct {
        alu16_op_t   o;
        logic [15:0] a, b;
        logic [3:0]  f;
        logic [15:0] r;
        logic [3:0]  fl;
        string       name;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int dones;
        logic [15:0] r, r2;
        logic [3:0]  fl, fl2;
        alu16_op_t   ro;
        logic [15:0] ra, rb;
        logic [3:0]  rf;

        tbl[0] = '{ADD16,     16'h8A23, 16'h0605, 4'b1000, 16'h9028, 4'b1010, "add16_a"};
        tbl[1] = '{ADD16,     16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011, "add16_wrap"};
        tbl[2] = '{ADD_SP_E8, 16'hFFF8, 16'h0008, 4'b0000, 16'h0000, 4'b0011, "sp_pos"};
        tbl[3] = '{ADD_SP_E8, 16'h0000, 16'h00FF, 4'b0000, 16'hFFFF, 4'b0000, "sp_neg"};
        tbl[4] = '{INC16,     16'h00FF, 16'h0000, 4'b1010, 16'h0100, 4'b1010, "inc16"};
        tbl[5] = '{DEC16,     16'h0000, 16'h0000, 4'b1010, 16'hFFFF, 4'b1010, "dec16"};

        rst_n = 1'b0; start = 1'b0; op = ADD16;
        operand_a = 16'h0; operand_b = 16'h0; flags_in = 4'h0;
        repeat (2) @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", 32'(result), 32'd0);
        check("rst flags", 32'(flags_out), 32'd0);
        check("rst instr", 32'(instruction), 32'(ALU_NOP));
        check("rst cin", 32'(carry_in), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            do_op(tbl[i].o, tbl[i].a, tbl[i].b, tbl[i].f, tbl[i].r, tbl[i].fl, tbl[i].name);
        end

        // Random ops; about half are launched back-to-back from the DONE cycle.
        for (int i = 0; i < 40; i++) begin
            ro = alu16_op_t'($urandom_range(3));
            ra = 16'($urandom);
            rb = 16'($urandom);
            rf = 4'($urandom);
            if ($urandom_range(3) == 0) ra[7:0] = ($urandom_range(1) == 1) ? 8'hFF : 8'h00;
            ref_model(ro, ra, rb, rf, r, fl);
            if ($urandom_range(1) == 1) @(negedge clk);
            do_op(ro, ra, rb, rf, r, fl, "random");
        end

        // start pulsed during LOW must be dropped.
        @(negedge clk);
        start = 1'b1; op = ADD16; operand_a = 16'h1234; operand_b = 16'h1111; flags_in = 4'h0;
        @(negedge clk);
        op = INC16; operand_a = 16'h0000;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        r2 = 16'h0;
        fl2 = 4'h0;
        for (int i = 0; i < 8; i++) begin
            if (done) begin dones++; r2 = result; fl2 = flags_out; end
            @(negedge clk);
        end
        ref_model(ADD16, 16'h1234, 16'h1111, 4'h0, r, fl);
        check("ignore start done count", 32'(dones), 32'd1);
        check("ignore start result", 32'(r2), 32'(r));
        check("ignore start flags", 32'(fl2), 32'(fl));
        $display("seq ignore-start-in-low dones=%0d result=%04h", dones, r2);

        // start in the DONE cycle is accepted with the normal 3-cycle latency.
        ref_model(ADD16, 16'h0F00, 16'h0100, 4'h0, r, fl);
        do_op(ADD16, 16'h0F00, 16'h0100, 4'h0, r, fl, "b2b_first");
        ref_model(DEC16, 16'h1000, 16'h0000, 4'b0101, r, fl);
        do_op(DEC16, 16'h1000, 16'h0000, 4'b0101, r, fl, "b2b_second");

        // Reset during HIGH aborts with no done.
        @(negedge clk);
        start = 1'b1; op = INC16; operand_a = 16'hABCD; operand_b = 16'h0; flags_in = 4'hF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort result", 32'(result), 32'd0);
        check("abort flags", 32'(flags_out), 32'd0);
        check("abort instr", 32'(instruction), 32'(ALU_NOP));
        check("abort cin", 32'(carry_in), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("abort no done", 32'(dones), 32'd0);
        check("abort result held", 32'(result), 32'd0);
        $display("seq reset-in-high dones=%0d result=%04h", dones, result);
        ref_model(ADD_SP_E8, 16'h1000, 16'h0080, 4'hF, r, fl);
        do_op(ADD_SP_E8, 16'h1000, 16'h0080, 4'hF, r, fl, "after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gb_cpu_alu16_seq.md
# gb_cpu_alu16_seq

Multi-cycle sequencer that runs the Game Boy 16-bit arithmetic instructions (ADD HL,rr; ADD SP,e8 / LD HL,SP+e8; INC rr; DEC rr) on the shared 8-bit `gb_cpu_alu`. It sits directly upstream of the ALU and issues two byte-wide `alu_instruction_t` operations, low byte then high byte, chaining the carry between them. It consumes the ALU's `out` and Z/N/H/C, then returns a 16-bit result and the architectural flags to the register-file writeback.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when the sequencer is idle.
- `op`  in  `alu16_op_t`  one of ADD16, ADD_SP_E8, INC16, DEC16.
- `operand_a`  in  16  HL, SP or rr (the first operand).
- `operand_b`  in  16  rr for ADD16; e8 in [7:0] for ADD_SP_E8; ignored otherwise.
- `flags_in`  in  4  current {Z,N,H,C}.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse; `result` and `flags_out` are valid.
- `result`  out  16  16-bit result.
- `flags_out`  out  4  {Z,N,H,C} to write back.
- `instruction`  out  `alu_instruction_t`  drives the ALU.
- `carry_in`  out  1  drives the ALU carry input.
- `out`  in  8  ALU result.
- `Z`, `N`, `H`, `C`  in  1 each  ALU flags.

## Operation
State machine states: IDLE, LOW, HIGH, DONE.
- **IDLE**
  - `start`=1 latches `op`, `operand_a`, `operand_b` and `flags_in`, then goes to LOW.
  - Otherwise stays in IDLE.
- **LOW**
  - Issues the low byte:
    - ADD16 and ADD_SP_E8: ADD a[7:0],b[7:0].
    - INC16: ADD a[7:0],1.
    - DEC16: SUB a[7:0],1.
  - `carry_in`=0.
  - Registers `out`, H and C, then goes to HIGH.
- **HIGH**
  - Issues the high byte:
    - ADD16: ADC a[15:8],b[15:8].
    - ADD_SP_E8: ADC a[15:8], where the second operand is 0xFF if e8[7]=1, else 0x00.
    - INC16: ADC a[15:8],0.
    - DEC16: SBC a[15:8],0.
  - `carry_in` = the C registered in LOW.
  - Registers `out`, H and C, then goes to DONE.
- **DONE**
  - `done`=1 and `busy`=0.
  - `start`=1 in this cycle is accepted, as from IDLE, and goes to LOW.
  - Otherwise goes to IDLE.
- Flag rules:
  - ADD16: Z=latched Z; N=0; H and C from the high-byte step (bit 11 and bit 15 carries).
  - ADD_SP_E8: Z=0; N=0; H and C from the low-byte step.
  - INC16 and DEC16: `flags_out` = latched `flags_in`.
- Arithmetic is modulo 2^16; wrap-around is not flagged beyond the rules above.
- `start` while `busy`=1 is ignored. It is neither queued nor reported.
- In IDLE and DONE, `instruction` = {ADD, 0x00, 0x00} and `carry_in`=0.

## Timing
- Reset values:
  - State IDLE; `busy`=0; `done`=0.
  - `result`=0x0000; `flags_out`=0.
  - `instruction`={ADD,0,0}; `carry_in`=0.
- `rst_n` low in any state aborts immediately to the reset values. No `done` is produced for the aborted operation.
- ALU path: `instruction` and `carry_in` are registered outputs, valid for the whole LOW or HIGH cycle. The ALU is combinational; its `out` and flags are sampled at the end of that same cycle.
- Latency:
  - `start` sampled at edge 0; LOW in cycle 1; HIGH in cycle 2; `done` high in cycle 3.
  - Back-to-back throughput is one operation per 3 cycles.
- `busy`=1 exactly in LOW and HIGH.
- `result` and `flags_out` update at the edge entering DONE. They hold until the next DONE or reset.

## Structure
- `gb_cpu_common_pkg` gains:
  - `alu16_op_t` (2-bit enum: ADD16, ADD_SP_E8, INC16, DEC16).
  - A flag-index constant set (Z=3, N=2, H=1, C=0) shared with the flag register.
- ALU opcodes ADD, ADC, SUB and SBC are taken from the package's existing opcode enum.
- No sub-module. The ALU is instantiated next to this block by the datapath, not inside it. The bench instantiates both.

## Test plan
- ADD16: a=0x8A23, b=0x0605, flags_in Z=1 → `result`=0x9028, flags {Z=1,N=0,H=1,C=0}, `done` in cycle 3.
- ADD16: a=0xFFFF, b=0x0001, flags_in=0 → `result`=0x0000, flags {Z=0,N=0,H=1,C=1}.
- ADD_SP_E8:
  - SP=0xFFF8, e8=0x08 → 0x0000, flags {0,0,1,1}.
  - SP=0x0000, e8=0xFF → 0xFFFF, flags {0,0,0,0}.
- INC16 0x00FF → 0x0100 and DEC16 0x0000 → 0xFFFF, each with flags_in=0b1010 → `flags_out`=0b1010.
- `start` pulsed during LOW is ignored (exactly one `done`). A `start` in the DONE cycle is accepted, giving a second `done` 3 cycles later.
- `rst_n` asserted during HIGH → all outputs at reset values immediately, no `done`. The next `start` after release completes normally.
